// File: rtl/uart_video_cfg_pkg.sv
// Shared types and constants for the UART video configuration controller:
// FSM states, command/response codes, pattern codes and payload lengths.
package uart_video_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHECK,
        ST_RESP,
        ST_RESP2
    } state_t;

    localparam logic [7:0] CMD_SET_PATTERN = 8'h01;
    localparam logic [7:0] CMD_SET_COLOR   = 8'h02;
    localparam logic [7:0] CMD_GET_STATUS  = 8'h03;

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    localparam logic [1:0] PAT_BARS     = 2'd0;
    localparam logic [1:0] PAT_SOLID    = 2'd1;
    localparam logic [1:0] PAT_GRADIENT = 2'd2;
    localparam logic [1:0] PAT_BLACK    = 2'd3;

    localparam logic [2:0] LEN_SET_PATTERN = 3'd1;
    localparam logic [2:0] LEN_SET_COLOR   = 3'd4;
    localparam logic [2:0] LEN_GET_STATUS  = 3'd0;

    // First payload byte carries a small field; its unused upper bits must be zero.
    function automatic logic reserved_bits_ok(input logic [7:0] cmd, input logic [7:0] first);
        case (cmd)
            CMD_SET_PATTERN: reserved_bits_ok = (first[7:2] == 6'd0);
            CMD_SET_COLOR:   reserved_bits_ok = (first[7:3] == 5'd0);
            default:         reserved_bits_ok = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cfg_timeout_timer.sv
// Inter-byte watchdog: reloads on clear, counts down while run is high and
// flags expire once LIMIT running cycles pass without a clear.
module cfg_timeout_timer #(
    parameter int unsigned LIMIT = 54000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] RELOAD = W'(LIMIT - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= RELOAD;
        end else if (clear) begin
            cnt_reg <= RELOAD;
        end else if (run && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign expire = run && !clear && (cnt_reg == '0);

endmodule

// File: rtl/uart_video_cfg_ctrl.sv
// Packet parser between the UART byte streams and the video colour generator:
// validates SYNC/CMD/payload/CHK frames, applies config and answers ACK/NAK.
module uart_video_cfg_ctrl
    import uart_video_cfg_pkg::*;
#(
    parameter int unsigned CLK_FRE    = 27,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [7:0]  I_rx_data,
    input  logic        I_rx_data_valid,
    output logic        O_rx_data_ready,
    output logic [7:0]  O_tx_data,
    output logic        O_tx_data_valid,
    input  logic        I_tx_data_ready,
    output logic [1:0]  O_pattern,
    output logic        O_pal_we,
    output logic [2:0]  O_pal_idx,
    output logic [23:0] O_pal_data,
    output logic [7:0]  O_err_cnt
);
    state_t      state_reg;
    logic        rx_ready_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_valid_reg;
    logic [1:0]  pattern_reg;
    logic        pal_we_reg;
    logic [2:0]  pal_idx_reg;
    logic [23:0] pal_data_reg;
    logic [7:0]  err_cnt_reg;
    logic [7:0]  cmd_reg;
    logic [2:0]  len_reg;
    logic [2:0]  idx_reg;
    logic [7:0]  xor_reg;
    logic        bad_reg;
    logic        status_pending_reg;
    logic [7:0]  buf_reg [0:3];

    logic rx_accept;
    logic timer_run;
    logic timeout;
    logic [7:0] err_cnt_next;

    assign rx_accept    = I_rx_data_valid && rx_ready_reg;
    assign timer_run    = (state_reg == ST_CMD) || (state_reg == ST_PAYLOAD) || (state_reg == ST_CHECK);
    assign err_cnt_next = (err_cnt_reg == 8'hFF) ? err_cnt_reg : err_cnt_reg + 8'd1;

    cfg_timeout_timer #(
        .LIMIT(CLK_FRE * TIMEOUT_US)
    ) u_timer (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .clear (rx_accept),
        .run   (timer_run),
        .expire(timeout)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg          <= ST_IDLE;
            rx_ready_reg       <= 1'b0;
            tx_data_reg        <= 8'd0;
            tx_valid_reg       <= 1'b0;
            pattern_reg        <= PAT_BARS;
            pal_we_reg         <= 1'b0;
            pal_idx_reg        <= 3'd0;
            pal_data_reg       <= 24'd0;
            err_cnt_reg        <= 8'd0;
            cmd_reg            <= 8'd0;
            len_reg            <= 3'd0;
            idx_reg            <= 3'd0;
            xor_reg            <= 8'd0;
            bad_reg            <= 1'b0;
            status_pending_reg <= 1'b0;
            for (int i = 0; i < 4; i++) buf_reg[i] <= 8'd0;
        end else begin
            pal_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    rx_ready_reg <= 1'b1;
                    if (rx_accept && I_rx_data == SYNC_BYTE) begin
                        state_reg <= ST_CMD;
                        bad_reg   <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (timeout) begin
                        state_reg   <= ST_IDLE;
                        err_cnt_reg <= err_cnt_next;
                    end else if (rx_accept) begin
                        cmd_reg <= I_rx_data;
                        xor_reg <= I_rx_data;
                        idx_reg <= 3'd0;
                        case (I_rx_data)
                            CMD_SET_PATTERN: begin len_reg <= LEN_SET_PATTERN; state_reg <= ST_PAYLOAD; end
                            CMD_SET_COLOR:   begin len_reg <= LEN_SET_COLOR;   state_reg <= ST_PAYLOAD; end
                            CMD_GET_STATUS:  begin len_reg <= LEN_GET_STATUS;  state_reg <= ST_CHECK;   end
                            default: begin
                                // Unknown command: treat the next byte as CHK and NAK it.
                                len_reg   <= 3'd0;
                                bad_reg   <= 1'b1;
                                state_reg <= ST_CHECK;
                            end
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (timeout) begin
                        state_reg   <= ST_IDLE;
                        err_cnt_reg <= err_cnt_next;
                    end else if (rx_accept) begin
                        buf_reg[idx_reg[1:0]] <= I_rx_data;
                        xor_reg <= xor_reg ^ I_rx_data;
                        idx_reg <= idx_reg + 3'd1;
                        if (idx_reg == len_reg - 3'd1) state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (timeout) begin
                        state_reg   <= ST_IDLE;
                        err_cnt_reg <= err_cnt_next;
                    end else if (rx_accept) begin
                        rx_ready_reg <= 1'b0;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_RESP;
                        if (I_rx_data == xor_reg && !bad_reg && reserved_bits_ok(cmd_reg, buf_reg[0])) begin
                            tx_data_reg        <= RESP_ACK;
                            status_pending_reg <= (cmd_reg == CMD_GET_STATUS);
                            if (cmd_reg == CMD_SET_PATTERN) pattern_reg <= buf_reg[0][1:0];
                            if (cmd_reg == CMD_SET_COLOR) begin
                                pal_we_reg   <= 1'b1;
                                pal_idx_reg  <= buf_reg[0][2:0];
                                pal_data_reg <= {buf_reg[1], buf_reg[2], buf_reg[3]};
                            end
                        end else begin
                            tx_data_reg        <= RESP_NAK;
                            status_pending_reg <= 1'b0;
                            err_cnt_reg        <= err_cnt_next;
                        end
                    end
                end
                ST_RESP: begin
                    if (I_tx_data_ready) begin
                        if (status_pending_reg) begin
                            tx_data_reg <= {err_cnt_reg[5:0], pattern_reg};
                            state_reg   <= ST_RESP2;
                        end else begin
                            tx_valid_reg <= 1'b0;
                            rx_ready_reg <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end
                    end
                end
                ST_RESP2: begin
                    if (I_tx_data_ready) begin
                        tx_valid_reg <= 1'b0;
                        rx_ready_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign O_rx_data_ready = rx_ready_reg;
    assign O_tx_data       = tx_data_reg;
    assign O_tx_data_valid = tx_valid_reg;
    assign O_pattern       = pattern_reg;
    assign O_pal_we        = pal_we_reg;
    assign O_pal_idx       = pal_idx_reg;
    assign O_pal_data      = pal_data_reg;
    assign O_err_cnt       = err_cnt_reg;

endmodule
